// File: rtl/pool_layer.sv
`timescale 1ns/1ps
// pool_layer: 2x2 / stride-2 max or average pooling over a raster-order
// multi-channel pixel stream, with strt/bsy frame handshake and done pulse.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   strt      single-cycle frame start pulse (ignored while bsy)
//   din_vld   din holds a valid pixel this cycle
//   din       CH signed samples, channel c at [c*DATA_W +: DATA_W]
//   bsy       frame in progress (registered)
//   dout_vld  dout holds a pooled pixel this cycle (registered)
//   dout      pooled pixel, same packing as din (registered)
//   done      single-cycle end-of-frame pulse (registered)
module pool_layer #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned CH     = 2,
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned IMG_H  = 28,
  parameter int unsigned MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strt,
  input  logic                 din_vld,
  input  logic [CH*DATA_W-1:0] din,
  output logic                 bsy,
  output logic                 dout_vld,
  output logic [CH*DATA_W-1:0] dout,
  output logic                 done
);

  localparam int unsigned EW  = DATA_W + 2;
  localparam int unsigned CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned LBN = IMG_W / 2;
  localparam int unsigned LBW = (LBN > 1) ? $clog2(LBN) : 1;

  // Reject image geometries that cannot tile into 2x2 windows
  if (IMG_W < 2 || (IMG_W % 2) != 0) begin : g_bad_img_w
    $error("pool_layer: IMG_W must be even and >= 2");
  end
  if (IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_img_h
    $error("pool_layer: IMG_H must be even and >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, next_state;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [LBW-1:0] lb_idx;
  logic           accept;
  logic           last_px;
  logic           odd_odd;

  logic signed [EW-1:0] h      [CH];
  logic signed [EW-1:0] lb     [CH][LBN];
  logic signed [EW-1:0] x_ext  [CH];
  logic signed [EW-1:0] cmb_h  [CH];
  logic signed [EW-1:0] cmb_lb [CH];
  logic [CH*DATA_W-1:0] dout_nx;

  // Max or sum; the extended width holds a 4-sample sum without overflow
  function automatic logic signed [EW-1:0] combine(input logic signed [EW-1:0] a,
                                                   input logic signed [EW-1:0] b);
    if (MODE == 0) return (a > b) ? a : b;
    else           return a + b;
  endfunction

  assign accept  = (state == S_RUN) && din_vld;
  assign last_px = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign odd_odd = row[0] && col[0];
  assign lb_idx  = LBW'(col >> 1);

  // Per-channel combine paths and pooled result
  always_comb begin
    dout_nx = '0;
    for (int c = 0; c < int'(CH); c++) begin
      x_ext[c]  = EW'($signed(din[c*DATA_W +: DATA_W]));
      cmb_h[c]  = combine(h[c], x_ext[c]);
      cmb_lb[c] = combine(lb[c][lb_idx], x_ext[c]);
      // Average mode divides the 4-sample sum by flooring arithmetic shift
      dout_nx[c*DATA_W +: DATA_W] = DATA_W'((MODE == 1) ? (cmb_h[c] >>> 2) : cmb_h[c]);
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (strt) next_state = S_RUN;
      S_RUN:   if (accept && last_px) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Frame status outputs, registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bsy  <= 1'b0;
      done <= 1'b0;
    end else begin
      bsy  <= (next_state != S_IDLE);
      done <= (next_state == S_DONE);
    end
  end

  // Raster position of the next accepted pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (state == S_IDLE && strt) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Holding register, line buffer and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(CH); c++) begin
        h[c] <= '0;
        for (int i = 0; i < int'(LBN); i++) lb[c][i] <= '0;
      end
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= accept && odd_odd;
      if (accept) begin
        for (int c = 0; c < int'(CH); c++) begin
          case ({row[0], col[0]})
            2'b00:   h[c] <= x_ext[c];
            2'b01:   lb[c][lb_idx] <= cmb_h[c];
            2'b10:   h[c] <= cmb_lb[c];
            default: ;
          endcase
        end
        if (odd_odd) dout <= dout_nx;
      end
    end
  end

endmodule

// File: tb/tb_pool_layer.sv
`timescale 1ns/1ps
// Self-checking bench for pool_layer: max and average 4x4 instances share a
// stimulus stream, a 2x2 average instance covers the saturation extremes.
module tb_pool_layer;

  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          strt, din_vld;
  logic [2*DW-1:0] din;
  logic          strt2, vld2;
  logic [2*DW-1:0] din2;

  logic bsy_m, vld_m, done_m; logic [2*DW-1:0] dout_m;
  logic bsy_a, vld_a, done_a; logic [2*DW-1:0] dout_a;
  logic bsy_s, vld_s, done_s; logic [2*DW-1:0] dout_s;

  pool_layer #(.DATA_W(DW), .CH(2), .IMG_W(4), .IMG_H(4), .MODE(0)) u_max (
    .clk(clk), .rst(rst), .strt(strt), .din_vld(din_vld), .din(din),
    .bsy(bsy_m), .dout_vld(vld_m), .dout(dout_m), .done(done_m));

  pool_layer #(.DATA_W(DW), .CH(2), .IMG_W(4), .IMG_H(4), .MODE(1)) u_avg (
    .clk(clk), .rst(rst), .strt(strt), .din_vld(din_vld), .din(din),
    .bsy(bsy_a), .dout_vld(vld_a), .dout(dout_a), .done(done_a));

  pool_layer #(.DATA_W(DW), .CH(2), .IMG_W(2), .IMG_H(2), .MODE(1)) u_sml (
    .clk(clk), .rst(rst), .strt(strt2), .din_vld(vld2), .din(din2),
    .bsy(bsy_s), .dout_vld(vld_s), .dout(dout_s), .done(done_s));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  int pix [2][16];
  int strt_cyc;

  int om0[$], om1[$], oa0[$], oa1[$], ocyc[$], os0[$], os1[$];
  int done_cyc[$], done_a_n, done_s_n, bsy_after[$], bsy_rise[$], exp_cyc[$];
  bit done_m_d = 1'b0;
  bit bsy_m_d  = 1'b0;

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  // Reference: pooled value of window (r,k) of a w-wide image in pix
  function automatic int ref_pool(input int mode, input int c, input int w,
                                  input int r, input int k);
    int p[4];
    int s, m;
    p[0] = pix[c][2*r*w + 2*k];
    p[1] = pix[c][2*r*w + 2*k + 1];
    p[2] = pix[c][(2*r+1)*w + 2*k];
    p[3] = pix[c][(2*r+1)*w + 2*k + 1];
    s = 0; m = p[0];
    for (int i = 0; i < 4; i++) begin
      s += p[i];
      if (p[i] > m) m = p[i];
    end
    if (mode == 0) return m;
    if (s >= 0) return s / 4;
    return -((-s + 3) / 4);
  endfunction

  function automatic logic [2*DW-1:0] pack(input int i);
    return {DW'(pix[1][i]), DW'(pix[0][i])};
  endfunction

  function automatic logic [2*DW-1:0] rnd_word();
    return (2*DW)'({$urandom(), $urandom()});
  endfunction

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (vld_m) begin
        om0.push_back(sx(dout_m[0 +: DW])); om1.push_back(sx(dout_m[DW +: DW]));
        ocyc.push_back(cyc);
      end
      if (vld_a) begin
        oa0.push_back(sx(dout_a[0 +: DW])); oa1.push_back(sx(dout_a[DW +: DW]));
      end
      if (vld_s) begin
        os0.push_back(sx(dout_s[0 +: DW])); os1.push_back(sx(dout_s[DW +: DW]));
      end
      if (done_m) done_cyc.push_back(cyc);
      if (done_a) done_a_n++;
      if (done_s) done_s_n++;
      if (done_m_d) bsy_after.push_back(int'(bsy_m));
      if (bsy_m && !bsy_m_d) bsy_rise.push_back(cyc);
    end
    done_m_d = done_m;
    bsy_m_d  = bsy_m;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input bit sel, input logic s, input logic v, input logic [2*DW-1:0] d);
    if (sel) begin strt2 = s; vld2 = v; din2 = d; end
    else     begin strt = s;  din_vld = v; din = d; end
  endtask

  task automatic clear_q();
    om0.delete(); om1.delete(); oa0.delete(); oa1.delete(); ocyc.delete();
    os0.delete(); os1.delete(); done_cyc.delete(); bsy_after.delete();
    bsy_rise.delete(); exp_cyc.delete();
    done_a_n = 0; done_s_n = 0;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 16; i++) begin pix[0][i] = i; pix[1][i] = -i; end
  endtask

  // Drive one frame; gap = percent chance of an idle cycle before each pixel
  task automatic run_frame(input bit sel, input int w, input int h, input int gap,
                           input bit junk, input int mid_strt);
    clear_q();
    if (junk) for (int j = 0; j < 3; j++) begin set_in(sel, 1'b0, 1'b1, rnd_word()); tick(); end
    set_in(sel, 1'b1, junk, junk ? rnd_word() : '0);
    strt_cyc = cyc;
    tick();
    for (int i = 0; i < w*h; i++) begin
      for (int g = 0; g < 6; g++) begin
        if (gap == 0 || $urandom_range(99) >= gap) break;
        set_in(sel, 1'b0, 1'b0, rnd_word()); tick();
      end
      set_in(sel, (i == mid_strt), 1'b1, pack(i));
      if (((i / w) % 2 == 1) && ((i % w) % 2 == 1)) exp_cyc.push_back(cyc + 1);
      tick();
    end
    set_in(sel, 1'b0, junk, junk ? rnd_word() : '0);
    for (int j = 0; j < 6; j++) tick();
    set_in(sel, 1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({bsy_m, vld_m, done_m, dout_m} !== '0) $display("FAIL reset_max: got %h expected 0", {bsy_m, vld_m, done_m, dout_m});
    else passes++;
    checks++;
    if ({bsy_a, vld_a, done_a, dout_a} !== '0) $display("FAIL reset_avg: got %h expected 0", {bsy_a, vld_a, done_a, dout_a});
    else passes++;
    checks++;
    if ({bsy_s, vld_s, done_s, dout_s} !== '0) $display("FAIL reset_sml: got %h expected 0", {bsy_s, vld_s, done_s, dout_s});
    else passes++;
  endtask

  task automatic test_max_avg();
    load_ramp();
    run_frame(1'b0, 4, 4, 0, 1'b0, -1);
    checks++;
    if (om0.size() != 4 || oa0.size() != 4) $display("FAIL basic_count: got %0d/%0d expected 4", om0.size(), oa0.size());
    else passes++;
    for (int i = 0; i < om0.size() && i < 4; i++) begin
      checks++;
      if (om0[i] !== ref_pool(0, 0, 4, i/2, i%2) || om1[i] !== ref_pool(0, 1, 4, i/2, i%2))
        $display("FAIL basic_max[%0d]: got %0d,%0d expected %0d,%0d", i, om0[i], om1[i],
                 ref_pool(0, 0, 4, i/2, i%2), ref_pool(0, 1, 4, i/2, i%2));
      else passes++;
    end
    for (int i = 0; i < oa0.size() && i < 4; i++) begin
      checks++;
      if (oa0[i] !== ref_pool(1, 0, 4, i/2, i%2) || oa1[i] !== ref_pool(1, 1, 4, i/2, i%2))
        $display("FAIL basic_avg[%0d]: got %0d,%0d expected %0d,%0d", i, oa0[i], oa1[i],
                 ref_pool(1, 0, 4, i/2, i%2), ref_pool(1, 1, 4, i/2, i%2));
      else passes++;
    end
    checks++;
    if (done_cyc.size() != 1 || ocyc.size() != 4 || done_cyc[0] != ocyc[3])
      $display("FAIL done_align: got %0d done pulses, first at cycle %0d, expected 1 at cycle %0d",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, (ocyc.size() == 4) ? ocyc[3] : -1);
    else passes++;
    checks++;
    if (bsy_after.size() != 1 || bsy_after[0] != 0) $display("FAIL bsy_drop: got %0d samples expected one low", bsy_after.size());
    else passes++;
    checks++;
    if (bsy_rise.size() != 1 || bsy_rise[0] != strt_cyc + 1)
      $display("FAIL bsy_rise: got cycle %0d expected %0d", (bsy_rise.size() > 0) ? bsy_rise[0] : -1, strt_cyc + 1);
    else passes++;
    checks++;
    if (done_a_n != 1) $display("FAIL avg_done: got %0d expected 1", done_a_n);
    else passes++;
  endtask

  task automatic test_avg_extremes();
    int vals[2];
    vals[0] = 131071; vals[1] = -131072;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 4; i++) begin pix[0][i] = vals[t]; pix[1][i] = vals[t]; end
      run_frame(1'b1, 2, 2, 0, 1'b0, -1);
      checks++;
      if (os0.size() != 1 || done_s_n != 1) $display("FAIL ext_count[%0d]: got %0d outputs %0d done expected 1/1", t, os0.size(), done_s_n);
      else passes++;
      checks++;
      if (os0.size() < 1 || os0[0] !== ref_pool(1, 0, 2, 0, 0) || os1[0] !== ref_pool(1, 1, 2, 0, 0))
        $display("FAIL ext_val[%0d]: got %0d,%0d expected %0d", t, (os0.size() > 0) ? os0[0] : 0,
                 (os1.size() > 0) ? os1[0] : 0, ref_pool(1, 0, 2, 0, 0));
      else passes++;
    end
  endtask

  // Shared body for scenarios checked against the reference on the 4x4 pair
  task automatic test_gaps();
    load_ramp();
    run_frame(1'b0, 4, 4, 50, 1'b0, -1);
    checks++;
    if (om0.size() != 4 || oa0.size() != 4) $display("FAIL gap_count: got %0d/%0d expected 4", om0.size(), oa0.size());
    else passes++;
    for (int i = 0; i < om0.size() && i < 4 && i < oa0.size(); i++) begin
      checks++;
      if (om0[i] !== ref_pool(0, 0, 4, i/2, i%2) || om1[i] !== ref_pool(0, 1, 4, i/2, i%2) ||
          oa0[i] !== ref_pool(1, 0, 4, i/2, i%2) || oa1[i] !== ref_pool(1, 1, 4, i/2, i%2))
        $display("FAIL gap_val[%0d]: got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d", i,
                 om0[i], om1[i], oa0[i], oa1[i], ref_pool(0, 0, 4, i/2, i%2), ref_pool(0, 1, 4, i/2, i%2),
                 ref_pool(1, 0, 4, i/2, i%2), ref_pool(1, 1, 4, i/2, i%2));
      else passes++;
      checks++;
      if (ocyc[i] != exp_cyc[i]) $display("FAIL gap_latency[%0d]: got cycle %0d expected %0d", i, ocyc[i], exp_cyc[i]);
      else passes++;
    end
  endtask

  task automatic test_strt_ignored();
    load_ramp();
    run_frame(1'b0, 4, 4, 0, 1'b1, 6);
    checks++;
    if (om0.size() != 4 || done_cyc.size() != 1 || bsy_rise.size() != 1)
      $display("FAIL strt_count: got %0d outputs %0d done %0d starts expected 4/1/1", om0.size(), done_cyc.size(), bsy_rise.size());
    else passes++;
    for (int i = 0; i < om0.size() && i < 4 && i < oa0.size(); i++) begin
      checks++;
      if (om0[i] !== ref_pool(0, 0, 4, i/2, i%2) || om1[i] !== ref_pool(0, 1, 4, i/2, i%2) ||
          oa0[i] !== ref_pool(1, 0, 4, i/2, i%2) || oa1[i] !== ref_pool(1, 1, 4, i/2, i%2))
        $display("FAIL strt_val[%0d]: got %0d,%0d,%0d,%0d", i, om0[i], om1[i], oa0[i], oa1[i]);
      else passes++;
    end
  endtask

  task automatic test_rst_mid();
    int n_before;
    load_ramp();
    clear_q();
    set_in(1'b0, 1'b1, 1'b0, '0); tick();
    for (int i = 0; i < 9; i++) begin set_in(1'b0, 1'b0, 1'b1, pack(i)); tick(); end
    n_before = om0.size();
    rst = 1'b1;
    #1;
    checks++;
    if ({bsy_m, vld_m, done_m, dout_m} !== '0 || {bsy_a, vld_a, done_a, dout_a} !== '0)
      $display("FAIL rst_mid_zero: got %h / %h expected 0", {bsy_m, vld_m, done_m, dout_m}, {bsy_a, vld_a, done_a, dout_a});
    else passes++;
    tick(); tick();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, '0);
    for (int j = 0; j < 6; j++) tick();
    checks++;
    if (om0.size() != n_before || done_cyc.size() != 0 || bsy_m !== 1'b0)
      $display("FAIL rst_mid_abort: got %0d outputs %0d done bsy %b expected %0d/0/0", om0.size(), done_cyc.size(), bsy_m, n_before);
    else passes++;
    run_frame(1'b0, 4, 4, 0, 1'b0, -1);
    checks++;
    if (om0.size() != 4 || done_cyc.size() != 1) $display("FAIL rst_rerun_count: got %0d/%0d expected 4/1", om0.size(), done_cyc.size());
    else passes++;
    for (int i = 0; i < om0.size() && i < 4 && i < oa0.size(); i++) begin
      checks++;
      if (om0[i] !== ref_pool(0, 0, 4, i/2, i%2) || om1[i] !== ref_pool(0, 1, 4, i/2, i%2) ||
          oa0[i] !== ref_pool(1, 0, 4, i/2, i%2) || oa1[i] !== ref_pool(1, 1, 4, i/2, i%2))
        $display("FAIL rst_rerun_val[%0d]: got %0d,%0d,%0d,%0d", i, om0[i], om1[i], oa0[i], oa1[i]);
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 16; i++) begin
        pix[0][i] = sx(DW'($urandom())); pix[1][i] = sx(DW'($urandom()));
      end
      run_frame(1'b0, 4, 4, (f == 0) ? 0 : 30, 1'b0, -1);
      checks++;
      if (om0.size() != 4 || oa0.size() != 4 || done_cyc.size() != 1)
        $display("FAIL rand_count[%0d]: got %0d/%0d/%0d expected 4/4/1", f, om0.size(), oa0.size(), done_cyc.size());
      else passes++;
      for (int i = 0; i < om0.size() && i < 4 && i < oa0.size(); i++) begin
        checks++;
        if (om0[i] !== ref_pool(0, 0, 4, i/2, i%2) || om1[i] !== ref_pool(0, 1, 4, i/2, i%2) ||
            oa0[i] !== ref_pool(1, 0, 4, i/2, i%2) || oa1[i] !== ref_pool(1, 1, 4, i/2, i%2))
          $display("FAIL rand_val[%0d][%0d]: got %0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d", f, i,
                   om0[i], om1[i], oa0[i], oa1[i], ref_pool(0, 0, 4, i/2, i%2), ref_pool(0, 1, 4, i/2, i%2),
                   ref_pool(1, 0, 4, i/2, i%2), ref_pool(1, 1, 4, i/2, i%2));
        else passes++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    strt = 1'b0; din_vld = 1'b0; din = '0;
    strt2 = 1'b0; vld2 = 1'b0; din2 = '0;
    tick(); tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_max_avg();
    test_avg_extremes();
    test_gaps();
    test_strt_ignored();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pool_layer.md
# pool_layer

Parametrised 2x2/stride-2 pooling layer for the CNN pipeline. It is the generalised successor to the fixed two-channel max-pool stage between convolution layers, with configurable channel count, image size and data width, and a selectable max or average mode. It consumes a raster-order stream of multi-channel pixels from a convolution layer and emits one pooled pixel per 2x2 window to the next layer. It uses the pipeline's strt/bsy frame handshake plus a done pulse.

## Interface
- DATA_W, 18: width of one signed two's-complement channel sample
- CH, 2: channels processed in parallel
- IMG_W, 28: input image width in pixels; must be even and ≥2 (elaboration error otherwise)
- IMG_H, 28: input image height in pixels; must be even and ≥2 (elaboration error otherwise)
- MODE, 0: 0 = max pooling, 1 = average pooling

- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- strt  in  1  single-cycle pulse that starts a frame
- din_vld  in  1  din carries a valid pixel this cycle
- din  in  CH*DATA_W  channel c occupies [c*DATA_W +: DATA_W]
- bsy  out  1  frame in progress
- dout_vld  out  1  dout holds a pooled pixel this cycle
- dout  out  CH*DATA_W  pooled pixel, same channel packing as din
- done  out  1  single-cycle end-of-frame pulse

## Operation
- FSM states:
  - IDLE: bsy=0. On strt, go to RUN and clear the row/col counters.
  - RUN: accept pixels and pool them. After the pixel at (IMG_H-1, IMG_W-1) is accepted, go to DONE.
  - DONE: one cycle, then return to IDLE.
- Input acceptance:
  - A pixel is accepted only when din_vld=1 in RUN.
  - din_vld in IDLE or DONE is ignored.
  - din_vld in the same cycle as strt is ignored.
  - strt while bsy=1 is ignored.
- Gaps in din_vld are allowed at any point. The counters advance only on accepted pixels.
- The counters run col 0..IMG_W-1 and row 0..IMG_H-1. col wraps to 0 and row increments on the last column.
- Per-channel combine function:
  - MODE=0: signed max.
  - MODE=1: signed sum, DATA_W+2 bits, so it cannot overflow.
- Storage:
  - Holding register h, one per channel.
  - Line buffer lb with IMG_W/2 entries per channel, each DATA_W+2 bits wide.
- Processing of an accepted pixel x at (row, col):
  - Even row, even col: h ← x.
  - Even row, odd col: lb[col>>1] ← combine(h, x).
  - Odd row, even col: h ← combine(lb[col>>1], x).
  - Odd row, odd col: r = combine(h, x). dout ← r in MODE=0, or r>>>2 (arithmetic shift, floor) in MODE=1. dout_vld=1 on the next cycle.
- Output count is exactly (IMG_W/2)*(IMG_H/2) per frame, in raster order.
- There is no downstream back-pressure. The consumer must accept every dout_vld.

## Timing
- Reset state: FSM in IDLE, counters 0, and bsy, dout_vld, done, dout, h and lb all 0.
- Asserting rst mid-frame aborts the frame immediately; no partial output or done follows.
- bsy goes high the cycle after strt is sampled. It stays high through the DONE cycle and goes low the cycle after DONE.
- Latency: dout_vld asserts 1 cycle after the accepting edge of every odd-row/odd-col pixel. dout is stable only while dout_vld=1 and holds its last value otherwise.
- DONE cycle: the last pooled pixel's dout_vld and done are high together.
- A new strt is accepted from the first IDLE cycle after DONE.
- Sustained throughput is 1 pixel per cycle with no bubbles required.

## Test plan
1. Max, CH=2, 4x4 (DATA_W=18, IMG_W=IMG_H=4, MODE=0); ch0 = 0..15 raster, ch1 = -(0..15); din_vld continuous -> exactly 4 outputs:
   - ch0: 5, 7, 13, 15.
   - ch1: 0, -2, -8, -10.
   - done coincides with the 4th dout_vld; bsy drops on the next cycle.
2. Avg, same stimulus with MODE=1 -> outputs:
   - ch0: 2, 4, 10, 12.
   - ch1: -3, -5, -11, -13 (floor).
3. Avg extremes, 2x2 image:
   - All samples +131071 -> 131071.
   - All samples -131072 -> -131072 (no overflow).
4. Random din_vld gaps with 50% duty on the test 1 image -> identical output values and order; output count 4; each dout_vld lands 1 cycle after the corresponding odd/odd pixel.
5. strt pulsed mid-frame, and din_vld held high in IDLE -> no restart, no extra outputs, and frame results unchanged.
6. rst asserted after 9 pixels of a 4x4 frame -> all outputs 0 immediately. A following full frame then produces test 1 results exactly, with no residue from lb or h.
